axi_ram_slave: RTL

- AXI4 slave memory model and FPGA on-chip backing store.
- Sits directly downstream of the cache's AXI master back-end and serves its write-through single beats, write-back line bursts and line-fill read bursts.
- Single outstanding transaction. Memory is an internal byte-writable register array.

---
 rtl/axi_ram_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave backed by a byte-writable on-chip word array.
// It serves one transaction at a time: INCR write bursts, INCR read bursts,
// or single beats. A write request beats a read request presented in the
// same IDLE cycle, so write-through data lands before any later line fill.
//
// Optional build macro: AXI_RAM_LATENCY_EN
//   When defined, an RWAIT state holds the read for RD_LAT cycles after the
//   AR handshake, so the first rvalid appears RD_LAT+1 cycles after it.
//   RD_LAT must then be at least 1.
//   When undefined, the first read beat follows the AR handshake by one
//   cycle and RD_LAT has no effect.
//
// Handshake rule on every channel: a beat transfers on a rising clk edge
// where valid and ready are both high. This block never withdraws a valid
// before it is accepted, and it holds the payload stable while valid & !ready.
//
// Debug visibility: the FSM state is the enum register state_q.
module axi_ram_slave #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 12,
  parameter int RD_LAT     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // write address
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W    = AXI_DATA_W / 8;
  localparam int BYTE_W    = $clog2(STRB_W);
  localparam int MEM_DEPTH = 2 ** MEM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WRESP = 3'd2,
    S_RDATA = 3'd3
`ifdef AXI_RAM_LATENCY_EN
    ,
    S_RWAIT = 3'd4
`endif
  } state_e;

  // Backing store; never cleared by reset.
  logic [AXI_DATA_W-1:0] mem_q [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q,  addr_d;   // next word to write / read
  logic [AXI_LEN_W-1:0]  cnt_q,   cnt_d;    // beats remaining after the current one
  logic [AXI_ID_W-1:0]   id_q,    id_d;
  logic                  err_q,   err_d;    // wlast misplaced somewhere in the burst
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  rlast_q, rlast_d;
  logic                  mem_we;
`ifdef AXI_RAM_LATENCY_EN
  logic [31:0]           lat_q,   lat_d;
`endif

  // Word index of each request: low byte-lane bits and bits above the
  // memory size are dropped, so every address aliases into the array.
  logic [MEM_ADDR_W-1:0] aw_word, ar_word;
  assign aw_word = s_axi_awaddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
  assign ar_word = s_axi_araddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];

  // Ignored address bits, plus RD_LAT in builds without RWAIT.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, 32'(RD_LAT)};

  // Channel outputs come straight from the state; readies and valids are
  // forced low while reset is held.
  assign s_axi_awready = (state_q == S_IDLE) && !reset;
  assign s_axi_arready = (state_q == S_IDLE) && !reset && !s_axi_awvalid;
  assign s_axi_wready  = (state_q == S_WDATA) && !reset;
  assign s_axi_bvalid  = (state_q == S_WRESP) && !reset;
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = {err_q, 1'b0};
  assign s_axi_rvalid  = (state_q == S_RDATA) && !reset;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rlast_q && (state_q == S_RDATA) && !reset;

  // Next-state logic: accepts requests, steps the burst counter and address,
  // and prefetches the next read word into rdata_d on each accepted beat.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rlast_d = rlast_q;
    mem_we  = 1'b0;
`ifdef AXI_RAM_LATENCY_EN
    lat_d   = lat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s_axi_awvalid) begin
          id_d    = s_axi_awid;
          addr_d  = aw_word;
          cnt_d   = s_axi_awlen;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end else if (s_axi_arvalid) begin
          id_d    = s_axi_arid;
          cnt_d   = s_axi_arlen;
`ifdef AXI_RAM_LATENCY_EN
          addr_d  = ar_word;
          lat_d   = 32'd0;
          state_d = S_RWAIT;
`else
          rdata_d = mem_q[ar_word];
          addr_d  = ar_word + 1'b1;
          rlast_d = (s_axi_arlen == '0);
          state_d = S_RDATA;
`endif
        end
      end
      S_WDATA: begin
        if (s_axi_wvalid) begin
          mem_we = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          // wlast must be high on the final counted beat and nowhere else.
          if (s_axi_wlast != (cnt_q == '0)) err_d = 1'b1;
          // The burst ends on the count regardless of wlast.
          if (cnt_q == '0) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (s_axi_bready) state_d = S_IDLE;
      end
`ifdef AXI_RAM_LATENCY_EN
      S_RWAIT: begin
        if (lat_q == 32'(RD_LAT - 1)) begin
          rdata_d = mem_q[addr_q];
          addr_d  = addr_q + 1'b1;
          rlast_d = (cnt_q == '0);
          state_d = S_RDATA;
        end else begin
          lat_d = lat_q + 32'd1;
        end
      end
`endif
      S_RDATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            rdata_d = mem_q[addr_q];
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            rlast_d = (cnt_q == AXI_LEN_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
`ifdef AXI_RAM_LATENCY_EN
      lat_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
`ifdef AXI_RAM_LATENCY_EN
      lat_q   <= lat_d;
`endif
    end
  end

  // Byte-lane writes into the array; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[addr_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

endmodule
